// File: rtl/srl_fifo_reader_if.sv
// Write/read handshake bundle for the SRL FIFO read end.
// master: the FIFO itself. slave: the producer/consumer environment.
interface srl_fifo_reader_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              WR_EN;
  logic [WIDTH-1:0]  WR_DATA;
  logic              FULL;
  logic              OVF;
  logic              M_VALID;
  logic              M_READY;
  logic [WIDTH-1:0]  M_DATA;
  logic [ADDR_W:0]   LEVEL;
  logic              EMPTY;

  modport master (
    input  WR_EN, WR_DATA, M_READY,
    output FULL, OVF, M_VALID, M_DATA, LEVEL, EMPTY
  );

  modport slave (
    output WR_EN, WR_DATA, M_READY,
    input  FULL, OVF, M_VALID, M_DATA, LEVEL, EMPTY
  );
endinterface

// File: rtl/srl_fifo_reader.sv
// Shallow SRL-backed FIFO: shift-in write storage, count-1 dynamic read address,
// registered valid/ready output stage holding the oldest word.
module srl_fifo_reader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                CLK,
  input  logic                RST,
  srl_fifo_reader_if.master   bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [WIDTH-1:0]  data [DEPTH];
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_m1;
  logic [ADDR_W-1:0] raddr;
  logic              is_full;
  logic              wr_acc;
  logic              ld;
  logic              m_valid;
  logic [WIDTH-1:0]  m_data;
  logic              ovf;

  // Accept/load decisions all work from the pre-edge count, so shift and read never race.
  always_comb begin
    is_full  = (count == CW'(DEPTH));
    wr_acc   = bus.WR_EN && !is_full;
    ld       = (count != '0) && (!m_valid || bus.M_READY);
    count_m1 = count - CW'(1);
    raddr    = count_m1[ADDR_W-1:0];
  end

  // SRL storage: no reset, shifts on every accepted write.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      data[0] <= bus.WR_DATA;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      ovf     <= 1'b0;
    end else begin
      ovf <= bus.WR_EN && is_full;
      if (ld) begin
        m_data  <= data[raddr];
        m_valid <= 1'b1;
      end else if (m_valid && bus.M_READY) begin
        m_valid <= 1'b0;
      end
      case ({wr_acc, ld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.FULL    = is_full;
  assign bus.EMPTY   = (count == '0) && !m_valid;
  assign bus.LEVEL   = count + CW'(m_valid);
  assign bus.M_VALID = m_valid;
  assign bus.M_DATA  = m_data;
  assign bus.OVF     = ovf;
endmodule

// File: tb/tb_srl_fifo_reader.sv
// Scoreboard bench for srl_fifo_reader: directed phases plus a random phase,
// with a negedge monitor checking data order, occupancy flags and OVF.
module tb_srl_fifo_reader;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic CLK;
  logic RST;
  srl_fifo_reader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  srl_fifo_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] sb_q [$];
  bit   mon_en = 1'b0;
  int   m_count;
  bit   m_valid;
  bit   m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: inputs are stable at negedge; check, then advance the model across the next edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("level", int'(bus.LEVEL), m_count + int'(m_valid));
      chk("full",  int'(bus.FULL),  int'(m_count == int'(DEPTH)));
      chk("empty", int'(bus.EMPTY), int'((m_count == 0) && !m_valid));
      chk("ovf",   int'(bus.OVF),   int'(m_ovf));
      chk("m_valid", int'(bus.M_VALID), int'(m_valid));
      if (bus.M_VALID) begin
        if (sb_q.size() == 0) begin
          chk("sb_underrun", 1, 0);
        end else begin
          chk("m_data", int'(bus.M_DATA), int'(sb_q[0]));
        end
      end
      if (RST) begin
        sb_q.delete();
        m_count = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end else begin
        bit wacc;
        bit ld;
        if (bus.M_VALID && bus.M_READY && sb_q.size() != 0) void'(sb_q.pop_front());
        wacc  = bus.WR_EN && (m_count != int'(DEPTH));
        ld    = (m_count > 0) && (!m_valid || bus.M_READY);
        m_ovf = bus.WR_EN && (m_count == int'(DEPTH));
        if (wacc) sb_q.push_back(bus.WR_DATA);
        if (ld) m_valid = 1'b1;
        else if (m_valid && bus.M_READY) m_valid = 1'b0;
        m_count = m_count + int'(wacc) - int'(ld);
      end
    end
  end

  // One clock: drive inputs, let the edge happen, return 1 time unit after it.
  task automatic cyc(input bit we, input logic [WIDTH-1:0] d, input bit rdy);
    bus.WR_EN   = we;
    bus.WR_DATA = d;
    bus.M_READY = rdy;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    bus.M_READY = 1'b0;
    @(posedge CLK); #1;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    RST = 1'b0;
    chk("rst_m_valid", int'(bus.M_VALID), 0);
    chk("rst_m_data",  int'(bus.M_DATA),  0);
    chk("rst_level",   int'(bus.LEVEL),   0);
    chk("rst_empty",   int'(bus.EMPTY),   1);
    chk("rst_full",    int'(bus.FULL),    0);
    chk("rst_ovf",     int'(bus.OVF),     0);
    m_count = 0; m_valid = 1'b0; m_ovf = 1'b0;
    mon_en = 1'b1;

    // Single word: one-cycle write-to-read latency, then held across stalls.
    cyc(1, 8'hA5, 0);
    chk("lat_m_valid_early", int'(bus.M_VALID), 0);
    chk("lat_level", int'(bus.LEVEL), 1);
    cyc(0, 8'h00, 0);
    chk("lat_m_valid", int'(bus.M_VALID), 1);
    chk("lat_m_data",  int'(bus.M_DATA), 'hA5);
    chk("lat_empty",   int'(bus.EMPTY), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0);
      chk("stall_m_data", int'(bus.M_DATA), 'hA5);
    end
    cyc(0, 8'h00, 1);
    chk("pop_empty", int'(bus.EMPTY), 1);

    // Fill 33 words, then overflow.
    for (int i = 0; i < 33; i++) begin
      cyc(1, WIDTH'(i), 0);
      if (i == 31) chk("fill_not_full", int'(bus.FULL), 0);
    end
    chk("fill_full",  int'(bus.FULL),  1);
    chk("fill_level", int'(bus.LEVEL), 33);
    cyc(1, 8'h55, 0);
    chk("ovf_pulse", int'(bus.OVF),   1);
    chk("ovf_level", int'(bus.LEVEL), 33);
    cyc(0, 8'h00, 0);
    chk("ovf_clear", int'(bus.OVF),   0);
    chk("ovf_m_data", int'(bus.M_DATA), 'h00);

    // Drain at full rate.
    cyc(0, 8'h00, 1);
    chk("drain_full_off", int'(bus.FULL), 0);
    chk("drain_first", int'(bus.M_DATA), 'h01);
    for (int i = 2; i <= 32; i++) cyc(0, 8'h00, 1);
    chk("drain_last", int'(bus.M_DATA), 'h20);
    chk("drain_last_valid", int'(bus.M_VALID), 1);
    cyc(0, 8'h00, 1);
    chk("drain_valid_off", int'(bus.M_VALID), 0);
    chk("drain_empty", int'(bus.EMPTY), 1);
    chk("drain_hold", int'(bus.M_DATA), 'h20);

    // Streaming: occupancy settles at one word in SRL plus one in the output register.
    for (int i = 0; i < 100; i++) begin
      cyc(1, WIDTH'(i), 1);
      if (i >= 1) chk("stream_level", int'(bus.LEVEL), 2);
      chk("stream_ovf", int'(bus.OVF), 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    chk("stream_empty", int'(bus.EMPTY), 1);

    // Random traffic; monitor carries all checks.
    for (int i = 0; i < 2000; i++) begin
      cyc(bit'($urandom_range(1)), WIDTH'($urandom), bit'($urandom_range(1)));
    end

    // Reset with 10 words buffered, writes and reads requested in the same cycle.
    for (int i = 0; i < 40; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 10; i++) cyc(1, WIDTH'(8'h80 + i), 0);
    chk("pre_rst_level", int'(bus.LEVEL), 10);
    RST = 1'b1;
    cyc(1, 8'h77, 1);
    RST = 1'b0;
    chk("mid_rst_m_valid", int'(bus.M_VALID), 0);
    chk("mid_rst_m_data",  int'(bus.M_DATA),  0);
    chk("mid_rst_level",   int'(bus.LEVEL),   0);
    chk("mid_rst_empty",   int'(bus.EMPTY),   1);
    cyc(1, 8'h3C, 0);
    cyc(0, 8'h00, 0);
    chk("post_rst_first", int'(bus.M_DATA), 'h3C);
    chk("post_rst_valid", int'(bus.M_VALID), 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    chk("final_empty", int'(bus.EMPTY), 1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
